// File: rtl/rc_byte_arbiter.sv
// rc_byte_arbiter: per-lane byte FIFOs feeding one shared BRAM write port, lane k packed at
// k<<REGION_AW. Define RC_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority instead of round-robin.
module rc_byte_arbiter #(
  parameter int unsigned N_LANES    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REGION_AW  = 12,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  input  logic [N_LANES-1:0]               i_lane_we,
  input  logic [8*N_LANES-1:0]             i_lane_byte,
  input  logic [N_LANES-1:0]               i_lane_done,
  output logic [N_LANES-1:0]               o_lane_ready,
  output logic                             o_bram_we,
  output logic [ADDR_W-1:0]                o_bram_addr,
  output logic [7:0]                       o_bram_din,
  output logic [(REGION_AW+1)*N_LANES-1:0] o_lane_len,
  output logic [N_LANES-1:0]               o_lane_ovf,
  output logic                             o_all_done
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = $clog2(N_LANES);
  localparam int unsigned LENW = REGION_AW + 1;
  localparam logic [LENW-1:0] LEN_MAX  = {1'b1, {REGION_AW{1'b0}}};
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    LANE_IDLE,
    LANE_ACTIVE,
    LANE_DRAIN,
    LANE_COMPLETE
  } lane_st_e;

  logic [7:0]         mem_q  [N_LANES][FIFO_DEPTH];
  logic [PW-1:0]      wptr_q [N_LANES];
  logic [PW-1:0]      wptr_d [N_LANES];
  logic [PW-1:0]      rptr_q [N_LANES];
  logic [PW-1:0]      rptr_d [N_LANES];
  logic [PW:0]        cnt_q  [N_LANES];
  logic [PW:0]        cnt_d  [N_LANES];
  logic [LENW-1:0]    len_q  [N_LANES];
  logic [LENW-1:0]    len_d  [N_LANES];
  lane_st_e           st_q   [N_LANES];
  lane_st_e           st_d   [N_LANES];
  logic [N_LANES-1:0] done_q, done_d;
  logic [N_LANES-1:0] ovf_q, ovf_d;
  logic               bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic               all_done_q, all_done_d;

  logic [N_LANES-1:0] full, empty, push_acc, cplt, pop;
  logic               gnt_vld;
  logic [LW-1:0]      gnt_idx;

  always_comb begin
    full     = '0;
    empty    = '0;
    push_acc = '0;
    cplt     = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      full[k]     = (cnt_q[k] == CNT_FULL);
      empty[k]    = (cnt_q[k] == '0);
      push_acc[k] = i_lane_we[k] & ~full[k];
      cplt[k]     = done_q[k] & empty[k] & ~push_acc[k];
    end
  end

`ifdef RC_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = N_LANES; i > 0; i--) begin
      if (!empty[i-1]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(i - 1);
      end
    end
  end
`else
  logic [LW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      idx = i + 32'(rr_ptr_q);
      if (idx >= N_LANES) idx = idx - N_LANES;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (i_clear)      rr_ptr_d = '0;
    else if (gnt_vld) rr_ptr_d = (gnt_idx == LW'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < N_LANES; k++) pop[k] = gnt_vld & (gnt_idx == LW'(k));
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    st_d       = st_q;
    done_d     = done_q | i_lane_done;
    ovf_d      = ovf_q | (i_lane_we & full);
    bram_we_d  = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    all_done_d = 1'b1;

    // A grant into a saturated region still pops the byte, but no write is issued.
    if (gnt_vld) begin
      if (len_q[gnt_idx] == LEN_MAX) begin
        ovf_d[gnt_idx] = 1'b1;
      end else begin
        bram_we_d      = 1'b1;
        addr_d         = (ADDR_W'(gnt_idx) << REGION_AW) | ADDR_W'(len_q[gnt_idx][REGION_AW-1:0]);
        din_d          = mem_q[gnt_idx][rptr_q[gnt_idx]];
        len_d[gnt_idx] = len_q[gnt_idx] + 1'b1;
      end
    end

    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (push_acc[k]) wptr_d[k] = wptr_q[k] + 1'b1;
      if (pop[k])      rptr_d[k] = rptr_q[k] + 1'b1;
      cnt_d[k] = cnt_q[k] + (PW+1)'(push_acc[k]) - (PW+1)'(pop[k]);

      case (st_q[k])
        LANE_IDLE: begin
          if (push_acc[k])  st_d[k] = LANE_ACTIVE;
          else if (cplt[k]) st_d[k] = LANE_COMPLETE;
        end
        LANE_ACTIVE: begin
          if (cplt[k])        st_d[k] = LANE_COMPLETE;
          else if (done_q[k]) st_d[k] = LANE_DRAIN;
        end
        LANE_DRAIN:    if (cplt[k]) st_d[k] = LANE_COMPLETE;
        LANE_COMPLETE: if (push_acc[k]) st_d[k] = LANE_DRAIN;
        default:       st_d[k] = LANE_IDLE;
      endcase

      if (i_clear) begin
        wptr_d[k] = '0;
        rptr_d[k] = '0;
        cnt_d[k]  = '0;
        len_d[k]  = '0;
        st_d[k]   = LANE_IDLE;
      end
    end

    if (i_clear) begin
      done_d    = '0;
      ovf_d     = '0;
      bram_we_d = 1'b0;
      addr_d    = addr_q;
      din_d     = din_q;
    end

    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (st_d[k] != LANE_COMPLETE) all_done_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N_LANES; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
        len_q[k]  <= '0;
        st_q[k]   <= LANE_IDLE;
      end
      done_q     <= '0;
      ovf_q      <= '0;
      bram_we_q  <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      all_done_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      st_q       <= st_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bram_we_q  <= bram_we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      all_done_q <= all_done_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers and counts.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (push_acc[k]) mem_q[k][wptr_q[k]] <= i_lane_byte[8*k +: 8];
    end
  end

  always_comb begin
    o_lane_len = '0;
    for (int unsigned k = 0; k < N_LANES; k++) o_lane_len[LENW*k +: LENW] = len_q[k];
  end

  assign o_lane_ready = ~full;
  assign o_bram_we    = bram_we_q;
  assign o_bram_addr  = addr_q;
  assign o_bram_din   = din_q;
  assign o_lane_ovf   = ovf_q;
  assign o_all_done   = all_done_q;

endmodule

// File: tb/tb_rc_byte_arbiter.sv
// Directed bench for rc_byte_arbiter: vector table for basic write ordering, then hand sequences
// for FIFO overflow, region saturation, done/drain, clear, arbitration fairness and async reset.
`timescale 1ns/1ps
module tb_rc_byte_arbiter;

`ifdef RC_ARB_FIXED_PRIO_EN
  localparam int EXP_ACC2 = 4;
  localparam int EXP_L3W  = 0;
`else
  localparam int EXP_ACC2 = 5;
  localparam int EXP_L3W  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  we;
  logic [31:0] bytes;
  logic [3:0]  done;
  logic [3:0]  rdy;
  logic        bwe;
  logic [31:0] baddr;
  logic [7:0]  bdin;
  logic [51:0] blen;
  logic [3:0]  ovf;
  logic        adone;

  logic        r_clr;
  logic [3:0]  r_we;
  logic [31:0] r_bytes;
  logic [3:0]  r_done;
  logic [3:0]  r_rdy;
  logic        r_bwe;
  logic [31:0] r_addr;
  logic [7:0]  r_din;
  logic [19:0] r_len;
  logic [3:0]  r_ovf;
  logic        r_adone;

  int checks = 0;
  int errors = 0;
  int wcnt [4];
  int n2, n_r;
  bit mon2, early_en;

  always #5 clk = ~clk;

  rc_byte_arbiter #(.N_LANES(4), .FIFO_DEPTH(4), .REGION_AW(12), .ADDR_W(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_lane_we(we), .i_lane_byte(bytes),
    .i_lane_done(done), .o_lane_ready(rdy), .o_bram_we(bwe), .o_bram_addr(baddr),
    .o_bram_din(bdin), .o_lane_len(blen), .o_lane_ovf(ovf), .o_all_done(adone)
  );

  rc_byte_arbiter #(.N_LANES(4), .FIFO_DEPTH(4), .REGION_AW(4), .ADDR_W(32)) u_r4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(r_clr), .i_lane_we(r_we), .i_lane_byte(r_bytes),
    .i_lane_done(r_done), .o_lane_ready(r_rdy), .o_bram_we(r_bwe), .o_bram_addr(r_addr),
    .o_bram_din(r_din), .o_lane_len(r_len), .o_lane_ovf(r_ovf), .o_all_done(r_adone)
  );

  typedef struct {
    logic [3:0]  we;
    logic [31:0] data;
    logic        clr;
    logic        e_we;
    logic [31:0] e_addr;
    logic [7:0]  e_din;
    logic [51:0] e_len;
  } vec_t;

  vec_t vt [12];

  function automatic logic [51:0] mk_len(int unsigned a0, int unsigned a1, int unsigned a2, int unsigned a3);
    return {13'(a3), 13'(a2), 13'(a1), 13'(a0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    int t;
    @(posedge clk);
    #1;
    if (bwe) wcnt[baddr[13:12]]++;
    if (mon2 && bwe && baddr[13:12] == 2'd2) begin
      chk("lane2_addr", baddr, 32'h2000 + n2);
      chk("lane2_din", bdin, 8'(8'h20 + n2));
      n2++;
    end
    if (r_bwe) begin
      chk("r4_addr", r_addr, n_r);
      chk("r4_din", r_din, 8'(8'h40 + n_r));
      n_r++;
    end
    t = wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3];
    if (early_en && t < 9) chk("all_done_early", adone, 1'b0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) wcnt[k] = 0;
  endtask

  initial begin
    int rem [4];
    int left;
    bit seen_nr;

    rst_n = 1'b0; clr = 1'b0; we = '0; bytes = '0; done = '0;
    r_clr = 1'b0; r_we = '0; r_bytes = '0; r_done = '0;
    for (int k = 0; k < 4; k++) wcnt[k] = 0;
    n2 = 0; n_r = 0; mon2 = 1'b0; early_en = 1'b0;

    vt[0]  = '{4'h0, 32'h0,        1'b0, 1'b0, 32'h0,    8'h00, mk_len(0, 0, 0, 0)};
    vt[1]  = '{4'hF, 32'h13121110, 1'b0, 1'b0, 32'h0,    8'h00, mk_len(0, 0, 0, 0)};
    vt[2]  = '{4'h0, 32'h0,        1'b0, 1'b1, 32'h0000, 8'h10, mk_len(1, 0, 0, 0)};
    vt[3]  = '{4'h0, 32'h0,        1'b0, 1'b1, 32'h1000, 8'h11, mk_len(1, 1, 0, 0)};
    vt[4]  = '{4'h0, 32'h0,        1'b0, 1'b1, 32'h2000, 8'h12, mk_len(1, 1, 1, 0)};
    vt[5]  = '{4'h0, 32'h0,        1'b0, 1'b1, 32'h3000, 8'h13, mk_len(1, 1, 1, 1)};
    vt[6]  = '{4'h0, 32'h0,        1'b0, 1'b0, 32'h3000, 8'h13, mk_len(1, 1, 1, 1)};
    vt[7]  = '{4'h5, 32'h00220020, 1'b0, 1'b0, 32'h3000, 8'h13, mk_len(1, 1, 1, 1)};
    vt[8]  = '{4'h8, 32'h33000000, 1'b1, 1'b0, 32'h3000, 8'h13, mk_len(0, 0, 0, 0)};
    vt[9]  = '{4'h0, 32'h0,        1'b0, 1'b0, 32'h3000, 8'h13, mk_len(0, 0, 0, 0)};
    vt[10] = '{4'h2, 32'h0000A500, 1'b0, 1'b0, 32'h3000, 8'h13, mk_len(0, 0, 0, 0)};
    vt[11] = '{4'h0, 32'h0,        1'b0, 1'b1, 32'h1000, 8'hA5, mk_len(0, 1, 0, 0)};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bwe, 1'b0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_len", blen, 52'h0);
    chk("rst_ovf", ovf, 4'h0);
    chk("rst_all_done", adone, 1'b0);
    chk("rst_ready", rdy, 4'hF);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      we = vt[i].we; bytes = vt[i].data; clr = vt[i].clr;
      tick();
      chk($sformatf("v%0d_we", i), bwe, vt[i].e_we);
      chk($sformatf("v%0d_addr", i), baddr, vt[i].e_addr);
      chk($sformatf("v%0d_din", i), bdin, vt[i].e_din);
      chk($sformatf("v%0d_len", i), blen, vt[i].e_len);
    end
    we = '0; clr = 1'b0;

    // FIFO overflow on lane 2 while the other lanes stream.
    do_clear();
    mon2 = 1'b1; n2 = 0; seen_nr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      we = 4'hF;
      bytes = {8'(8'h30 + c), 8'(8'h20 + c), 8'(8'h10 + c), 8'(8'h00 + c)};
      tick();
      if (!rdy[2]) seen_nr = 1'b1;
    end
    we = '0;
    chk("ready2_dropped", seen_nr, 1'b1);
    chk("ovf2_set", ovf[2], 1'b1);
    repeat (40) tick();
    chk("lane2_len", blen[38:26], 13'(EXP_ACC2));
    chk("lane2_writes", n2, EXP_ACC2);
    chk("ovf2_sticky", ovf[2], 1'b1);
    mon2 = 1'b0;

    // Clear while FIFOs hold data and a grant is due.
    we = 4'hF; bytes = 32'h44434241;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; we = '0;
    chk("clr_we", bwe, 1'b0);
    chk("clr_len", blen, 52'h0);
    chk("clr_ovf", ovf, 4'h0);
    tick();
    chk("clr_we_after", bwe, 1'b0);

    // Lane 0 streams while lane 3 has one byte waiting.
    do_clear();
    we = 4'b1001; bytes = 32'h99000050;
    tick();
    we = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      bytes = {24'h0, 8'(8'h51 + c)};
      tick();
    end
    we = '0;
    chk("lane3_writes", wcnt[3], EXP_L3W);
    repeat (10) tick();

    // Done/drain: 3,0,5,1 bytes then done pulse; all_done only after the 9th write.
    do_clear();
    rem[0] = 3; rem[1] = 0; rem[2] = 5; rem[3] = 1;
    early_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      left = rem[0] + rem[1] + rem[2] + rem[3];
      if (left != 0) begin
        we = '0;
        for (int k = 0; k < 4; k++) begin
          if (rem[k] > 0 && rdy[k]) begin
            we[k] = 1'b1;
            bytes[8*k +: 8] = 8'(8'h60 + 16*k + rem[k]);
          end
        end
        tick();
        for (int k = 0; k < 4; k++) if (we[k]) rem[k]--;
      end
    end
    we = '0;
    chk("done_pushed_all", rem[0] + rem[1] + rem[2] + rem[3], 0);
    done = 4'hF;
    tick();
    done = '0;
    for (int c = 0; c < 30; c++) if (!adone) tick();
    early_en = 1'b0;
    chk("all_done", adone, 1'b1);
    chk("done_writes", wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3], 9);
    chk("done_ovf", ovf, 4'h0);
    chk("done_len", blen, mk_len(3, 0, 5, 1));

    // Region saturation on the REGION_AW=4 instance.
    n_r = 0;
    for (int c = 0; c < 17; c++) begin
      r_we = 4'b0001; r_bytes = {24'h0, 8'(8'h40 + c)};
      tick();
    end
    r_we = '0;
    repeat (6) tick();
    chk("r4_writes", n_r, 16);
    chk("r4_len", r_len[4:0], 5'd16);
    chk("r4_ovf", r_ovf, 4'h1);

    // Async reset in the middle of a write.
    do_clear();
    we = 4'b0001; bytes = 32'h77;
    tick();
    tick();
    chk("pre_rst_we", bwe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", bwe, 1'b0);
    chk("arst_addr", baddr, 32'h0);
    chk("arst_din", bdin, 8'h0);
    chk("arst_len", blen, 52'h0);
    we = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", bwe, 1'b0);
    chk("post_rst_ready", rdy, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
